// File: rtl/mem_pkg.sv
// mem_pkg: constants shared by the memory stage.
//   - FSM state encoding (IDLE / BUSY)
//   - default widths for address, data and destination register index
//   - register-file write enable used when a store retires
package mem_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 4;

   // Stores never write the register file, whatever execute requested.
   localparam logic STORE_WB_REG_WRITE = 1'b0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: bounded-wait counter for an outstanding memory access.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   i_clear   in   hold the count at zero (asserted while no access is outstanding)
//   i_enable  in   count this cycle (access outstanding, no ack)
//   o_expire  out  count has reached TIMEOUT-1 while enabled: abort on the next edge
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_expire = i_enable && (r_cnt == TERM);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between execute and writeback.
// Non-memory instructions retire one cycle after acceptance. Loads/stores
// issue a registered request, stall execute until mem_ack or timeout, then
// retire a single wb_valid pulse.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   ex_*                     instruction from execute (valid, ALU result, store data, controls, dest)
//   stall                    execute must hold its outputs (every BUSY cycle)
//   mem_req/we/addr/wdata    registered data-memory request
//   mem_rdata, mem_ack       memory response (ack sampled only while mem_req)
//   wb_valid/reg_write/dest/data/err   registered MEM/WB outputs
//
// state | meaning
// IDLE  | accepting; ALU ops retire next edge, memory ops issue a request
// BUSY  | request outstanding; stall=1, waiting for ack or timeout
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic [REG_W-1:0]  ex_dest,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [REG_W-1:0]  wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_err
);

   logic [0:0]        r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_cap_reg_write;
   logic [REG_W-1:0]  r_cap_dest;
   logic              r_wb_valid;
   logic              r_wb_reg_write;
   logic [REG_W-1:0]  r_wb_dest;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_wb_err;

   logic w_busy;
   logic w_mem_op;
   logic w_expire;

   assign w_busy   = (r_state == ST_BUSY);
   assign w_mem_op = ex_mem_read || ex_mem_write;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (!w_busy),
      .i_enable (w_busy && !mem_ack),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_mem_req       <= 1'b0;
         r_mem_we        <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_cap_reg_write <= 1'b0;
         r_cap_dest      <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_reg_write  <= 1'b0;
         r_wb_dest       <= '0;
         r_wb_data       <= '0;
         r_wb_err        <= 1'b0;
      end else begin
         // wb_valid/wb_err are single-cycle pulses unless set below.
         r_wb_valid <= 1'b0;
         r_wb_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ex_valid) begin
                  if (w_mem_op) begin
                     r_state         <= ST_BUSY;
                     r_mem_req       <= 1'b1;
                     // read+write together resolves to a store
                     r_mem_we        <= ex_mem_write;
                     r_mem_addr      <= ex_alu_out[ADDR_W-1:0];
                     r_mem_wdata     <= ex_store_data;
                     r_cap_reg_write <= ex_reg_write;
                     r_cap_dest      <= ex_dest;
                  end else begin
                     r_wb_valid     <= 1'b1;
                     r_wb_reg_write <= ex_reg_write;
                     r_wb_dest      <= ex_dest;
                     r_wb_data      <= ex_alu_out;
                  end
               end
            end
            ST_BUSY: begin
               // ack has priority over a same-cycle timeout
               if (mem_ack) begin
                  r_state    <= ST_IDLE;
                  r_mem_req  <= 1'b0;
                  r_wb_valid <= 1'b1;
                  r_wb_dest  <= r_cap_dest;
                  if (r_mem_we) begin
                     r_wb_reg_write <= STORE_WB_REG_WRITE;
                     r_wb_data      <= DATA_W'(r_mem_addr);
                  end else begin
                     r_wb_reg_write <= r_cap_reg_write;
                     r_wb_data      <= mem_rdata;
                  end
               end else if (w_expire) begin
                  r_state        <= ST_IDLE;
                  r_mem_req      <= 1'b0;
                  r_wb_valid     <= 1'b1;
                  r_wb_err       <= 1'b1;
                  r_wb_reg_write <= 1'b0;
                  r_wb_dest      <= r_cap_dest;
                  r_wb_data      <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall        = w_busy;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign wb_valid     = r_wb_valid;
   assign wb_reg_write = r_wb_reg_write;
   assign wb_dest      = r_wb_dest;
   assign wb_data      = r_wb_data;
   assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_out;
   logic [31:0] ex_store_data;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic [3:0]  ex_dest;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic        wb_err;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  dest;
      logic        rw;
      logic        err;
   } wb_t;

   wb_t exp_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(16), .DATA_W(32), .REG_W(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_err(wb_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] dst, input logic rw, input logic err);
      wb_t e;
      e.data = d; e.dest = dst; e.rw = rw; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic idle_ex();
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
      ex_alu_out = '0; ex_store_data = '0; ex_dest = '0;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] sd, input logic rw, input logic [3:0] dst);
      ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_alu_out = alu;
      ex_store_data = sd; ex_reg_write = rw; ex_dest = dst;
   endtask

   // Monitor: every wb_valid pulse must match the oldest expected retire.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL wb_unexpected: got wb_valid=1 data=%h expected no writeback at %0t",
                        wb_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("wb_data", wb_data, e.data);
               chk("wb_dest", {28'h0, wb_dest}, {28'h0, e.dest});
               chk("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
               chk("wb_err", {31'h0, wb_err}, {31'h0, e.err});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; mem_ack = 0; mem_rdata = '0;
      idle_ex();
      tick(); tick();
      chk("rst_mem_req", {31'h0, mem_req}, 0);
      chk("rst_wb_valid", {31'h0, wb_valid}, 0);
      chk("rst_wb_err", {31'h0, wb_err}, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 0);
      chk("rst_stall", {31'h0, stall}, 0);
      rst = 0;

      // 1. ALU pass-through
      issue(0, 0, 32'h0000_1234, 0, 1, 4'd3);
      push(32'h1234, 4'd3, 1, 0);
      chk("t1_stall_pre", {31'h0, stall}, 0);
      tick();
      chk("t1_wb_valid", {31'h0, wb_valid}, 1);
      chk("t1_stall", {31'h0, stall}, 0);
      idle_ex();
      tick();
      chk("t1_wb_valid_off", {31'h0, wb_valid}, 0);

      // 2. Load, ack on 3rd BUSY cycle
      issue(1, 0, 32'h0000_0040, 0, 1, 4'd5);
      tick();
      idle_ex();
      chk("t2_mem_req", {31'h0, mem_req}, 1);
      chk("t2_mem_addr", {16'h0, mem_addr}, 32'h40);
      chk("t2_mem_we", {31'h0, mem_we}, 0);
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall_busy", {31'h0, stall}, 1);
         chk("t2_wb_quiet", {31'h0, wb_valid}, 0);
         if (i == 2) begin
            mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
            push(32'hDEAD_BEEF, 4'd5, 1, 0);
         end
         tick();
      end
      mem_ack = 0; mem_rdata = '0;
      chk("t2_stall_done", {31'h0, stall}, 0);
      chk("t2_req_done", {31'h0, mem_req}, 0);
      tick();

      // 3. Store (read+write both set, reg_write requested) then held ALU op
      issue(1, 1, 32'h0000_0010, 32'h55, 1, 4'd7);
      tick();
      chk("t3_mem_we", {31'h0, mem_we}, 1);
      chk("t3_mem_wdata", mem_wdata, 32'h55);
      chk("t3_mem_addr", {16'h0, mem_addr}, 32'h10);
      issue(0, 0, 32'h0000_ABCD, 0, 1, 4'd2);
      chk("t3_stall1", {31'h0, stall}, 1);
      tick();
      chk("t3_stall2", {31'h0, stall}, 1);
      chk("t3_wdata_stable", mem_wdata, 32'h55);
      mem_ack = 1;
      push(32'h10, 4'd7, 0, 0);
      push(32'hABCD, 4'd2, 1, 0);
      tick();
      mem_ack = 0;
      chk("t3_store_retire", {31'h0, wb_valid}, 1);
      chk("t3_stall_idle", {31'h0, stall}, 0);
      tick();
      idle_ex();
      chk("t3_alu_retire", {31'h0, wb_valid}, 1);
      tick();
      chk("t3_no_dup", {31'h0, wb_valid}, 0);

      // 4a. Timeout: no ack
      issue(1, 0, 32'h0000_0022, 0, 1, 4'd9);
      tick();
      idle_ex();
      for (int i = 0; i < 16; i++) begin
         chk("t4_req_high", {31'h0, mem_req}, 1);
         if (i == 15) push(32'h0, 4'd9, 0, 1);
         tick();
      end
      chk("t4_req_low", {31'h0, mem_req}, 0);
      chk("t4_wb_err", {31'h0, wb_err}, 1);
      chk("t4_stall_idle", {31'h0, stall}, 0);
      tick();
      chk("t4_err_pulse", {31'h0, wb_err}, 0);

      // 4b. Ack on 16th cycle wins over timeout
      issue(1, 0, 32'h0000_0033, 0, 1, 4'd4);
      tick();
      idle_ex();
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            mem_ack = 1; mem_rdata = 32'h1357_9BDF;
            push(32'h1357_9BDF, 4'd4, 1, 0);
         end
         tick();
      end
      mem_ack = 0; mem_rdata = '0;
      chk("t4b_wb_valid", {31'h0, wb_valid}, 1);
      chk("t4b_wb_err", {31'h0, wb_err}, 0);
      tick();

      // 5. Reset mid-access, late ack ignored
      issue(1, 0, 32'h0000_0044, 0, 1, 4'd6);
      tick();
      idle_ex();
      chk("t5_req", {31'h0, mem_req}, 1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("t5_req_rst", {31'h0, mem_req}, 0);
      chk("t5_stall_rst", {31'h0, stall}, 0);
      chk("t5_wb_valid_rst", {31'h0, wb_valid}, 0);
      mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
      tick();
      chk("t5_late_ack", {31'h0, wb_valid}, 0);
      chk("t5_req_late", {31'h0, mem_req}, 0);
      tick();
      mem_ack = 0;

      // 6. Spurious ack in IDLE, then confirm stage still accepts work
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      chk("t6_no_wb", {31'h0, wb_valid}, 0);
      chk("t6_stall", {31'h0, stall}, 0);
      tick();
      chk("t6_no_req", {31'h0, mem_req}, 0);
      mem_ack = 0; mem_rdata = '0;
      issue(0, 0, 32'h0000_0777, 0, 0, 4'd1);
      push(32'h777, 4'd1, 0, 0);
      tick();
      idle_ex();
      chk("t6_alu_after", {31'h0, wb_valid}, 1);
      tick(); tick();

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
